bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single system bus among up to NUM_MASTERS bus masters: the CPU IF port, the CPU MEM port, and future DMA/debug masters. It sits between the masters' active-low request/grant pins and the bus address/data multiplexer, which it steers with a registered owner index. Ownership is held per transaction, with an optional hold limit so a streaming master cannot starve the others.

---
 rtl/bus_rr_arbiter_pkg.sv | 16 +
 rtl/bus_rr_arbiter_rr_pick.sv | 30 +++
 rtl/bus_rr_arbiter.sv | 116 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus arbitration constants and state encoding for the round-robin bus arbiter.
package bus_rr_arbiter_pkg;

    localparam int NUM_MASTERS_DEF = 4;
    localparam int OWNER_W_DEF     = 2;
    localparam int MAX_HOLD_DEF    = 16;

    localparam int MASTER_IF  = 0;
    localparam int MASTER_MEM = 1;

    typedef enum logic {
        StIdle  = 1'b0,
        StOwned = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first active-low request at or after i_start, wrapping.
module bus_rr_arbiter_rr_pick
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int OWNER_W     = OWNER_W_DEF
) (
    input  logic [NUM_MASTERS-1:0] i_req_n,
    input  logic [OWNER_W-1:0]     i_start,
    output logic                   o_found,
    output logic [OWNER_W-1:0]     o_idx
);

    logic [OWNER_W-1:0] w_idx;

    // Scan from the far end back towards i_start so the nearest requester is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_idx = OWNER_W'((int'(i_start) + i) % NUM_MASTERS);
            if (!i_req_n[w_idx]) begin
                o_found = 1'b1;
                o_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with per-transaction ownership and an optional hold limit.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int OWNER_W     = OWNER_W_DEF,
    parameter int MAX_HOLD    = MAX_HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req_,
    input  logic [NUM_MASTERS-1:0] m_as_,
    output logic [NUM_MASTERS-1:0] m_grnt_,
    output logic [OWNER_W-1:0]     bus_owner,
    output logic                   bus_busy
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS - 1){1'b0}}, 1'b1};

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grnt_n;
    logic [OWNER_W-1:0]     r_owner;
    logic [OWNER_W-1:0]     r_last_owner;
    logic                   r_busy;
    logic [HOLD_W-1:0]      r_hold_cnt;

    logic [NUM_MASTERS-1:0] w_owner_bit;
    logic [NUM_MASTERS-1:0] w_req_n;
    logic [NUM_MASTERS-1:0] w_pick_bit;
    logic [OWNER_W-1:0]     w_start;
    logic [OWNER_W-1:0]     w_pick;
    logic                   w_found;
    logic                   w_hold_due;
    logic                   w_preempt;

    // The current owner is masked out so the pick only ever names another master.
    assign w_owner_bit = ONE << r_owner;
    assign w_req_n     = (r_state == StOwned) ? (m_req_ | w_owner_bit) : m_req_;
    assign w_start     = (r_last_owner == LAST_IDX) ? '0 : r_last_owner + 1'b1;
    assign w_pick_bit  = ONE << w_pick;

    bus_rr_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .OWNER_W     (OWNER_W)
    ) u_rr_pick (
        .i_req_n (w_req_n),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    generate
        if (MAX_HOLD > 0) begin : g_hold_limit
            assign w_hold_due = (int'(r_hold_cnt) >= MAX_HOLD - 1);
        end else begin : g_no_hold_limit
            assign w_hold_due = 1'b0;
        end
    endgenerate

    // Never preempt mid-transfer: owner's address strobe must be idle.
    assign w_preempt = w_hold_due && w_found && m_as_[r_owner];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_grnt_n     <= '1;
            r_owner      <= '0;
            r_last_owner <= LAST_IDX;
            r_busy       <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state      <= StOwned;
                        r_grnt_n     <= ~w_pick_bit;
                        r_owner      <= w_pick;
                        r_last_owner <= w_pick;
                        r_busy       <= 1'b1;
                        r_hold_cnt   <= '0;
                    end
                end
                StOwned: begin
                    if (m_req_[r_owner] || w_preempt) begin
                        if (w_found) begin
                            r_grnt_n     <= ~w_pick_bit;
                            r_owner      <= w_pick;
                            r_last_owner <= w_pick;
                            r_hold_cnt   <= '0;
                        end else begin
                            r_state    <= StIdle;
                            r_grnt_n   <= '1;
                            r_owner    <= '0;
                            r_busy     <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end else if (int'(r_hold_cnt) < MAX_HOLD) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_grnt_n <= '1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign m_grnt_   = r_grnt_n;
    assign bus_owner = r_owner;
    assign bus_busy  = r_busy;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench: two arbiters (hold limit 4 and 0) share stimulus and are checked
// against an abstract round-robin ownership model.
module tb_bus_rr_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] m_req_ = 4'hF;
    logic [3:0] m_as_ = 4'hF;
    logic [3:0] g4, g0;
    logic [1:0] o4, o0;
    logic       b4, b0;

    bus_rr_arbiter #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_as_     (m_as_),
        .m_grnt_   (g4),
        .bus_owner (o4),
        .bus_busy  (b4)
    );

    bus_rr_arbiter #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_as_     (m_as_),
        .m_grnt_   (g0),
        .bus_owner (o0),
        .bus_busy  (b0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g4, g0;
        logic [1:0] o4, o0;
        logic       b4, b0;
        bit         rst;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state per DUT: owner (-1 = nobody), last granted index, cycles held.
    int m_owner[2];
    int m_last[2];
    int m_hold[2];
    int mh[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int last, input logic [3:0] req, input int excl);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (!req[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic void model_step(input int k, input logic [3:0] req,
                                       input logic [3:0] asn, input bit rst);
        int p;
        if (rst) begin
            m_owner[k] = -1;
            m_last[k]  = N - 1;
            m_hold[k]  = 0;
        end else if (m_owner[k] < 0) begin
            p = pick(m_last[k], req, -1);
            if (p >= 0) begin
                m_owner[k] = p;
                m_last[k]  = p;
                m_hold[k]  = 0;
            end
        end else begin
            p = pick(m_last[k], req, m_owner[k]);
            if (req[m_owner[k]]) begin
                m_owner[k] = p;
                if (p >= 0) m_last[k] = p;
                m_hold[k] = 0;
            end else if (mh[k] != 0 && m_hold[k] >= mh[k] - 1 && p >= 0 && asn[m_owner[k]]) begin
                m_owner[k] = p;
                m_last[k]  = p;
                m_hold[k]  = 0;
            end else if (m_hold[k] < mh[k]) begin
                m_hold[k] = m_hold[k] + 1;
            end
        end
    endfunction

    function automatic exp_t mk_exp(input bit rst);
        exp_t e;
        e.rst = rst;
        e.b4  = (m_owner[0] >= 0);
        e.g4  = e.b4 ? ~(4'b0001 << m_owner[0]) : 4'hF;
        e.o4  = e.b4 ? 2'(m_owner[0]) : 2'd0;
        e.b0  = (m_owner[1] >= 0);
        e.g0  = e.b0 ? ~(4'b0001 << m_owner[1]) : 4'hF;
        e.o0  = e.b0 ? 2'(m_owner[1]) : 2'd0;
        return e;
    endfunction

    task automatic cyc(input logic [3:0] req, input logic [3:0] asn, input bit rst);
        @(negedge clk);
        m_req_ = req;
        m_as_  = asn;
        reset  = rst;
        model_step(0, req, asn, rst);
        model_step(1, req, asn, rst);
        sb_q.push_back(mk_exp(rst));
    endtask

    // Monitor: one expected response per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("grnt_h4", 32'(g4), 32'(e.g4));
                check("busy_h4", 32'(b4), 32'(e.b4));
                if (e.b4 || e.rst) check("owner_h4", 32'(o4), 32'(e.o4));
                check("grnt_h0", 32'(g0), 32'(e.g0));
                check("busy_h0", 32'(b0), 32'(e.b0));
                if (e.b0 || e.rst) check("owner_h0", 32'(o0), 32'(e.o0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] req;
        logic [3:0] asn;
        mh[0] = 4;
        mh[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = N - 1;
            m_hold[k]  = 0;
        end

        // Reset state, then reset priority: masters 0 and 1 request.
        cyc(4'hF, 4'hF, 1'b1);
        cyc(4'hF, 4'hF, 1'b1);
        cyc(4'b1100, 4'hF, 1'b0);
        cyc(4'b1100, 4'hF, 1'b0);

        // Rotation: all request, owner releases after two cycles of ownership.
        cyc(4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 14; i++) begin
            req = 4'b0000;
            if (m_owner[0] >= 0 && m_hold[0] >= 1) req[m_owner[0]] = 1'b1;
            cyc(req, 4'hF, 1'b0);
        end

        // Preemption with owner's strobe idle.
        cyc(4'hF, 4'hF, 1'b1);
        cyc(4'b1101, 4'hF, 1'b0);
        repeat (8) cyc(4'b1001, 4'hF, 1'b0);

        // Owner mid-transfer: no preemption until its strobe rises.
        cyc(4'hF, 4'hF, 1'b1);
        cyc(4'b1101, 4'b1101, 1'b0);
        repeat (6) cyc(4'b1001, 4'b1101, 1'b0);
        repeat (4) cyc(4'b1001, 4'hF, 1'b0);

        // Single requester for 100 cycles.
        cyc(4'hF, 4'hF, 1'b1);
        repeat (100) cyc(4'b0111, 4'hF, 1'b0);
        @(posedge clk);
        #2;
        check("hold_sat_h4", 32'(dut.r_hold_cnt), 32'd4);
        check("hold_sat_h0", 32'(dut0.r_hold_cnt), 32'd0);

        // Reset while master 2 owns the bus.
        cyc(4'hF, 4'hF, 1'b1);
        cyc(4'b1011, 4'hF, 1'b0);
        cyc(4'b1011, 4'hF, 1'b0);
        cyc(4'b1011, 4'hF, 1'b1);
        cyc(4'b1011, 4'hF, 1'b0);

        // Owner 0 releases as masters 1 and 3 request.
        cyc(4'hF, 4'hF, 1'b1);
        cyc(4'b1110, 4'hF, 1'b0);
        cyc(4'b1110, 4'hF, 1'b0);
        cyc(4'b0101, 4'hF, 1'b0);
        cyc(4'b0101, 4'hF, 1'b0);

        // Randomized traffic with sticky requests and occasional resets.
        cyc(4'hF, 4'hF, 1'b1);
        req = 4'hF;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            end
            asn = ~(~req & 4'($urandom_range(15)));
            cyc(req, asn, ($urandom_range(63) == 0));
        end
        cyc(4'hF, 4'hF, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
